// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared 640x480@60 Hz timing constants and the coordinate type.
//   H_*/V_*        default porch/sync/active widths
//   H_TOTAL/V_TOTAL  line and frame lengths
//   HS_*/VS_*      sync pulse window, START inclusive, END exclusive
//   coord_t        10-bit pixel/line coordinate
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// vga_wrap_counter: modulo-(MAX+1) counter that holds when en=0.
//   vga_clk  in   clock
//   reset    in   synchronous active-high reset; value returns to MAX
//   en       in   advance enable
//   value    out  current count, 0..MAX
//   wrap     out  high in the cycle whose advance takes value MAX -> 0
// Resetting to MAX means the first advance lands on 0 and raises wrap,
// which the top uses to start the first frame.
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter coord_t MAX = coord_t'(H_TOTAL - 1)
) (
    input  logic   vga_clk,
    input  logic   reset,
    input  logic   en,
    output coord_t value,
    output logic   wrap
);

    coord_t value_q, value_d;

    assign wrap = en && (value_q == MAX);

    always_comb begin
        value_d = value_q;
        if (wrap)    value_d = '0;
        else if (en) value_d = value_q + coord_t'(1);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) value_q <= MAX;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel coordinate, blank and sync timing source.
//   vga_clk      in   pixel-domain clock
//   reset        in   synchronous active-high reset
//   pix_en       in   pixel advance enable
//   DrawX/DrawY  out  current pixel / line counts
//   blank        out  1 = active display region
//   hs/vs        out  active-low syncs
//   line_start   out  one-advance strobe on entering x==0
//   frame_start  out  one-advance strobe on entering (0,0)
//   frame_count  out  completed frames since reset, mod 256
// blank/hs/vs are decoded from the next coordinates so they stay aligned
// with DrawX/DrawY instead of trailing them by a cycle.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam coord_t X_MAX = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t Y_MAX = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t X_ACT = coord_t'(H_ACTIVE);
    localparam coord_t Y_ACT = coord_t'(V_ACTIVE);
    localparam coord_t HS_LO = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_LO = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t x, y, x_d, y_d;
    logic   h_wrap, v_wrap;

    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       ls_q, fs_q;
    logic [7:0] fc_q, fc_d;
    // Set until the first advance: the wrap out of the reset state opens
    // frame 0 and must not be counted as a completed frame.
    logic       first_q, first_d;

    vga_wrap_counter #(.MAX(X_MAX)) u_hcnt (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (pix_en),
        .value   (x),
        .wrap    (h_wrap)
    );

    vga_wrap_counter #(.MAX(Y_MAX)) u_vcnt (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (h_wrap),
        .value   (y),
        .wrap    (v_wrap)
    );

    always_comb begin
        x_d     = h_wrap ? '0 : x + coord_t'(1);
        y_d     = v_wrap ? '0 : (h_wrap ? y + coord_t'(1) : y);
        blank_d = blank_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        fc_d    = fc_q;
        first_d = first_q;
        if (pix_en) begin
            blank_d = (x_d < X_ACT) && (y_d < Y_ACT);
            hs_d    = !((x_d >= HS_LO) && (x_d < HS_HI));
            vs_d    = !((y_d >= VS_LO) && (y_d < VS_HI));
            first_d = 1'b0;
        end
        if (v_wrap && !first_q) fc_d = fc_q + 8'd1;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 8'd0;
            first_q <= 1'b1;
        end else begin
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            // wraps already include pix_en, so held cycles clear the strobes
            ls_q    <= h_wrap;
            fs_q    <= v_wrap;
            fc_q    <= fc_d;
            first_q <= first_d;
        end
    end

    assign DrawX       = x;
    assign DrawY       = y;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Full-size instance for line-level timing, tiny instance (8x6) so that
    // whole frames and the frame_count wrap fit in a short run.
    localparam int S_HA = 4, S_HFP = 1, S_HS = 2, S_HBP = 1;
    localparam int S_VA = 3, S_VFP = 1, S_VS = 1, S_VBP = 1;
    localparam int S_FRAME = 48;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        bit r;
        bit e;
        int cyc;
        obs_t exp;
    } row_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    logic pix_en  = 1'b0;

    logic [9:0] dx, dy, sx, sy;
    logic       db, dh, dv, dls, dfs, sb, sh, sv, sls, sfs;
    logic [7:0] dfc, sfc;

    int vecs = 0;
    int errs = 0;

    longint n_d = 0, n_s = 0;
    bit     adv = 1'b0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_dut (
        .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
        .DrawX(dx), .DrawY(dy), .blank(db), .hs(dh), .vs(dv),
        .line_start(dls), .frame_start(dfs), .frame_count(dfc)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) u_sml (
        .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
        .DrawX(sx), .DrawY(sy), .blank(sb), .hs(sh), .vs(sv),
        .line_start(sls), .frame_start(sfs), .frame_count(sfc)
    );

    function automatic obs_t dut_obs();
        return '{dx, dy, db, dh, dv, dls, dfs, dfc};
    endfunction

    function automatic obs_t sml_obs();
        return '{sx, sy, sb, sh, sv, sls, sfs, sfc};
    endfunction

    function automatic obs_t mk(int x, int y, bit b, bit h, bit v, bit ls, bit fs, int fc);
        obs_t o;
        o.x = 10'(x); o.y = 10'(y); o.blank = b; o.hs = h; o.vs = v;
        o.ls = ls; o.fs = fs; o.fc = 8'(fc);
        return o;
    endfunction

    // Reference: n = advances since reset; position is (n-1) pixels into a
    // raster of ht*vt pixels, completed frames are (n-1) / (ht*vt).
    function automatic obs_t model(longint n, bit a, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp);
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        longint p;
        int x, y;
        if (n == 0) return mk(ht - 1, vt - 1, 0, 1, 1, 0, 0, 0);
        p = (n - 1) % longint'(ht * vt);
        x = int'(p % ht);
        y = int'(p / ht);
        return mk(x, y, (x < ha) && (y < va),
                  !((x >= ha + hfp) && (x < ha + hfp + hsw)),
                  !((y >= va + vfp) && (y < va + vfp + vsw)),
                  a && (x == 0), a && (x == 0) && (y == 0),
                  int'(((n - 1) / longint'(ht * vt)) % 256));
    endfunction

    task automatic cmp(input string name, input obs_t act, input obs_t exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     name, act.x, act.y, act.blank, act.hs, act.vs, act.ls, act.fs, act.fc,
                     exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit e);
        reset  = r;
        pix_en = e;
        @(posedge vga_clk);
        if (r) begin
            n_d = 0; n_s = 0; adv = 1'b0;
        end else if (e) begin
            n_d++; n_s++; adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        #1;
        cmp("model_full", dut_obs(), model(n_d, adv, 640, 16, 96, 48, 480, 10, 2, 33));
        cmp("model_small", sml_obs(),
            model(n_s, adv, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP));
    endtask

    row_t tbl[12];

    initial begin
        int t0, t1, k;
        bit e;

        tbl[0]  = '{1, 1, 3,   mk(799, 524, 0, 1, 1, 0, 0, 0)};
        tbl[1]  = '{0, 1, 1,   mk(0,   0,   1, 1, 1, 1, 1, 0)};
        tbl[2]  = '{0, 1, 1,   mk(1,   0,   1, 1, 1, 0, 0, 0)};
        tbl[3]  = '{0, 1, 638, mk(639, 0,   1, 1, 1, 0, 0, 0)};
        tbl[4]  = '{0, 1, 1,   mk(640, 0,   0, 1, 1, 0, 0, 0)};
        tbl[5]  = '{0, 1, 16,  mk(656, 0,   0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{0, 1, 95,  mk(751, 0,   0, 0, 1, 0, 0, 0)};
        tbl[7]  = '{0, 1, 1,   mk(752, 0,   0, 1, 1, 0, 0, 0)};
        tbl[8]  = '{0, 1, 47,  mk(799, 0,   0, 1, 1, 0, 0, 0)};
        tbl[9]  = '{0, 1, 1,   mk(0,   1,   1, 1, 1, 1, 0, 0)};
        tbl[10] = '{0, 0, 3,   mk(0,   1,   1, 1, 1, 0, 0, 0)};
        tbl[11] = '{0, 1, 1,   mk(1,   1,   1, 1, 1, 0, 0, 0)};

        @(negedge vga_clk);
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].r, tbl[i].e);
            cmp($sformatf("table_row%0d", i), dut_obs(), tbl[i].exp);
        end

        // Full frames on the small instance, then frame_count wrap 255 -> 0.
        step(1, 1);
        step(0, 1);
        cmp("sml_first", sml_obs(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        for (int c = 0; c < S_FRAME; c++) step(0, 1);
        cmp("sml_frame1", sml_obs(), mk(0, 0, 1, 1, 1, 1, 1, 1));
        for (int c = 0; c < 255 * S_FRAME; c++) step(0, 1);
        cmp("sml_fc_wrap", sml_obs(), mk(0, 0, 1, 1, 1, 1, 1, 0));

        // Alternating pix_en doubles the frame period; strobes never repeat.
        step(1, 1);
        t0 = -1; t1 = -1; k = 0;
        e = 1'b1;
        for (int c = 0; c < 4 * S_FRAME && t1 < 0; c++) begin
            step(0, e);
            e = ~e;
            k++;
            if (sfs) begin
                if (t0 < 0) t0 = k;
                else        t1 = k;
            end
        end
        chk("toggle_frame_seen", int'(t1 >= 0), 1);
        chk("toggle_period", t1 - t0, 2 * S_FRAME);

        // Reset mid-frame after one completed frame.
        step(1, 1);
        for (int c = 0; c < 1 + S_FRAME + 30; c++) step(0, 1);
        chk("mid_fc_before", int'(sfc), 1);
        chk("mid_x_before", int'(sx), 6);
        chk("mid_y_before", int'(sy), 3);
        step(1, 1);
        cmp("mid_reset_sml", sml_obs(), mk(7, 5, 0, 1, 1, 0, 0, 0));
        cmp("mid_reset_full", dut_obs(), mk(799, 524, 0, 1, 1, 0, 0, 0));
        step(0, 1);
        cmp("mid_restart_sml", sml_obs(), mk(0, 0, 1, 1, 1, 1, 1, 0));

        // Randomised enables with occasional resets against the model.
        for (int c = 0; c < 4000; c++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
